// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: FunctC codes, MIPS Funct/ALUOp
// field values and the sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] FC_AND = 4'b0000;
  localparam logic [3:0] FC_OR  = 4'b0001;
  localparam logic [3:0] FC_ADD = 4'b0010;
  localparam logic [3:0] FC_NOR = 4'b0011;
  localparam logic [3:0] FC_XOR = 4'b0100;
  localparam logic [3:0] FC_SUB = 4'b0110;
  localparam logic [3:0] FC_MUL = 4'b1010;
  localparam logic [3:0] FC_DIV = 4'b1111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Purely combinational ALUOp/Funct decode into FunctC plus operation class flags.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_funct_c,
  output logic       o_is_mul,
  output logic       o_is_div,
  output logic       o_is_mfhi,
  output logic       o_is_mflo,
  output logic       o_illegal
);

  always_comb begin
    o_funct_c = FC_ADD;
    o_is_mul  = 1'b0;
    o_is_div  = 1'b0;
    o_is_mfhi = 1'b0;
    o_is_mflo = 1'b0;
    o_illegal = 1'b0;
    case (i_alu_op)
      AOP_ADD: o_funct_c = FC_ADD;
      AOP_SUB: o_funct_c = FC_SUB;
      AOP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_funct_c = FC_ADD;
          FN_SUB:  o_funct_c = FC_SUB;
          FN_AND:  o_funct_c = FC_AND;
          FN_OR:   o_funct_c = FC_OR;
          FN_NOR:  o_funct_c = FC_NOR;
          FN_XOR:  o_funct_c = FC_XOR;
          FN_MULT: begin
            o_funct_c = FC_MUL;
            o_is_mul  = 1'b1;
          end
          FN_DIV: begin
            o_funct_c = FC_DIV;
            o_is_div  = 1'b1;
          end
          FN_MFHI: o_is_mfhi = 1'b1;
          FN_MFLO: o_is_mflo = 1'b1;
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: drives FunctC, stalls for multi-cycle mult/div and owns HI/LO.
// Optional macro HILO_BYPASS_EN forwards the value being captured to mfhi/mflo in DONE.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  Funct,
  input  logic        b_is_zero,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_rem,
  output logic [3:0]  FunctC,
  output logic        stall,
  output logic        op_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output logic        mf_valid,
  output logic        illegal,
  output logic        div_err,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_div;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_div_err;

  state_t      w_next_state;
  logic [3:0]  w_cnt_next;
  logic        w_is_div_next;
  logic        w_set_div_err;
  logic        w_capture;
  logic [31:0] w_hi_view;
  logic [31:0] w_lo_view;

  logic [3:0]  w_dec_fc;
  logic        w_dec_mul;
  logic        w_dec_div;
  logic        w_dec_mfhi;
  logic        w_dec_mflo;
  logic        w_dec_ill;

  alu_funct_decode u_decode (
    .i_alu_op  (ALUOp),
    .i_funct   (Funct),
    .o_funct_c (w_dec_fc),
    .o_is_mul  (w_dec_mul),
    .o_is_div  (w_dec_div),
    .o_is_mfhi (w_dec_mfhi),
    .o_is_mflo (w_dec_mflo),
    .o_illegal (w_dec_ill)
  );

`ifdef HILO_BYPASS_EN
  assign w_hi_view = (r_state == ST_DONE) ? (r_is_div ? alu_rem : 32'd0) : r_hi;
  assign w_lo_view = (r_state == ST_DONE) ? alu_out : r_lo;
`else
  assign w_hi_view = r_hi;
  assign w_lo_view = r_lo;
`endif

  // Handshake: an operation is taken when op_valid is high in IDLE or DONE; while
  // stall is high op_valid is ignored and upstream must hold its instruction.
  always_comb begin
    w_next_state  = r_state;
    w_cnt_next    = r_cnt;
    w_is_div_next = r_is_div;
    w_set_div_err = 1'b0;
    w_capture     = 1'b0;
    FunctC        = w_dec_fc;
    stall         = 1'b0;
    op_done       = 1'b0;
    mf_data       = 32'd0;
    mf_valid      = 1'b0;
    illegal       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (r_state == ST_DONE) begin
          op_done      = 1'b1;
          w_capture    = 1'b1;
          w_next_state = ST_IDLE;
        end
        if (w_dec_mfhi) mf_data = w_hi_view;
        if (w_dec_mflo) mf_data = w_lo_view;
        mf_valid = op_valid & (w_dec_mfhi | w_dec_mflo);
        illegal  = op_valid & w_dec_ill;
        if (op_valid && w_dec_mul) begin
          w_next_state  = ST_MUL_WAIT;
          w_cnt_next    = MUL_CNT_INIT;
          w_is_div_next = 1'b0;
        end else if (op_valid && w_dec_div) begin
          if (b_is_zero) begin
            w_set_div_err = 1'b1;
          end else begin
            w_next_state  = ST_DIV_WAIT;
            w_cnt_next    = DIV_CNT_INIT;
            w_is_div_next = 1'b1;
          end
        end
      end
      ST_MUL_WAIT, ST_DIV_WAIT: begin
        FunctC = (r_state == ST_MUL_WAIT) ? FC_MUL : FC_DIV;
        stall  = 1'b1;
        if (r_cnt == 4'd0) w_next_state = ST_DONE;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_is_div  <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_div_err <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_is_div <= w_is_div_next;
      if (w_set_div_err) r_div_err <= 1'b1;
      if (w_capture) begin
        r_lo <= alu_out;
        r_hi <= r_is_div ? alu_rem : 32'd0;
      end
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign div_err   = r_div_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq (MUL_LAT=4, DIV_LAT=8).
module tb_alu_control_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic        b_is_zero;
  logic [31:0] alu_out;
  logic [31:0] alu_rem;
  logic [3:0]  FunctC;
  logic        stall;
  logic        op_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;
  logic        mf_valid;
  logic        illegal;
  logic        div_err;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  alu_control_seq #(.MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .ALUOp(ALUOp), .Funct(Funct),
    .b_is_zero(b_is_zero), .alu_out(alu_out), .alu_rem(alu_rem), .FunctC(FunctC),
    .stall(stall), .op_done(op_done), .hi(hi), .lo(lo), .mf_data(mf_data),
    .mf_valid(mf_valid), .illegal(illegal), .div_err(div_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn);
    op_valid = v;
    ALUOp    = aop;
    Funct    = fn;
  endtask

  // Runs one mult/div from accept through the cycle after DONE. mf_in_done issues
  // an mflo in the DONE cycle.
  task automatic run_muldiv(input logic is_div, input logic [31:0] out, input logic [31:0] rem,
                            input int lat, input logic mf_in_done);
    logic [3:0] fc;
    fc = is_div ? 4'b1111 : 4'b1010;
    @(negedge clk);
    drive(1'b1, 2'b10, is_div ? 6'b011010 : 6'b011000);
    b_is_zero = 1'b0;
    alu_out   = out;
    alu_rem   = rem;
    #1;
    check("accept_fc", 32'(FunctC), 32'(fc));
    check("accept_stall", 32'(stall), 32'd0);
    exp_q.push_back(out);
    exp_q.push_back(is_div ? rem : 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b10, 6'b111111);
      #1;
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_fc", 32'(FunctC), 32'(fc));
      check("wait_ignored", 32'(illegal), 32'd0);
    end
    @(negedge clk);
    drive(mf_in_done, 2'b10, 6'b010010);
    #1;
    check("done_stall", 32'(stall), 32'd0);
    check("done_pulse", 32'(op_done), 32'd1);
    check("done_state", 32'(dbg_state), 32'd3);
    if (mf_in_done) begin
      check("done_mf_valid", 32'(mf_valid), 32'd1);
`ifdef HILO_BYPASS_EN
      check("done_mflo", mf_data, out);
`else
      check("done_mflo", mf_data, m_lo);
`endif
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 6'b000000);
    #1;
    m_lo = exp_q.pop_front();
    m_hi = exp_q.pop_front();
    check("cap_lo", lo, m_lo);
    check("cap_hi", hi, m_hi);
    check("post_done", 32'(op_done), 32'd0);
    check("post_state", 32'(dbg_state), 32'd0);
  endtask

  logic [5:0] fn_tab[6];
  logic [3:0] fc_tab[6];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100110};
    fc_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0100};
    reset = 1'b1;
    drive(1'b0, 2'b00, 6'b000000);
    b_is_zero = 1'b0;
    alu_out   = 32'd0;
    alu_rem   = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_fc", 32'(FunctC), 32'h2);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_err", 32'(div_err), 32'd0);
    check("rst_done", 32'(op_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b10, fn_tab[i]);
      #1;
      check("rtype_fc", 32'(FunctC), 32'(fc_tab[i]));
      check("rtype_stall", 32'(stall), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 2'b00, 6'b101010);
    #1;
    check("aop00_fc", 32'(FunctC), 32'h2);
    @(negedge clk);
    drive(1'b1, 2'b01, 6'b101010);
    #1;
    check("aop01_fc", 32'(FunctC), 32'h6);

    run_muldiv(1'b0, 32'h0000_0F0F, 32'hDEAD_BEEF, 4, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b010010);
    #1;
    check("mflo_valid", 32'(mf_valid), 32'd1);
    check("mflo_data", mf_data, 32'h0000_0F0F);

    run_muldiv(1'b1, 32'd7, 32'd3, 8, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b010000);
    #1;
    check("mfhi_data", mf_data, 32'd3);

    @(negedge clk);
    drive(1'b1, 2'b10, 6'b011010);
    b_is_zero = 1'b1;
    alu_out   = 32'h5555_5555;
    alu_rem   = 32'h6666_6666;
    #1;
    check("dz_stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 6'b000000);
    b_is_zero = 1'b0;
    #1;
    check("dz_err", 32'(div_err), 32'd1);
    check("dz_stall2", 32'(stall), 32'd0);
    check("dz_state", 32'(dbg_state), 32'd0);
    check("dz_hi", hi, 32'd3);
    check("dz_lo", lo, 32'd7);

    @(negedge clk);
    drive(1'b1, 2'b11, 6'b100000);
    #1;
    check("ill_aop", 32'(illegal), 32'd1);
    check("ill_aop_fc", 32'(FunctC), 32'h2);
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b111111);
    #1;
    check("ill_fn", 32'(illegal), 32'd1);
    check("ill_fn_fc", 32'(FunctC), 32'h2);
    @(negedge clk);
    drive(1'b0, 2'b11, 6'b111111);
    #1;
    check("ill_novalid", 32'(illegal), 32'd0);

    run_muldiv(1'b0, 32'h1234_5678, 32'h0, 4, 1'b1);
    check("sticky_err", 32'(div_err), 32'd1);

    @(negedge clk);
    drive(1'b1, 2'b10, 6'b011010);
    alu_out = 32'h0000_00AA;
    alu_rem = 32'h0000_00BB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 6'b000000);
    end
    #1;
    check("mid_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_fc", 32'(FunctC), 32'h2);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_err", 32'(div_err), 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("abort_lo", lo, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_done", 32'(op_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Drives the 4-bit FunctC code into the ALU-select datapath from the MIPS ALUOp and Funct fields.
- Sequences multi-cycle mult/div operations: holds FunctC and stalls the pipeline for a fixed latency, then captures the results into HI/LO.
- Serves mfhi/mflo reads.
- Sits between main control/decode and the ALU; it is the producer end of the FunctC interface.

Parameters:
MUL_LAT, 4, cycles FunctC=1010 is held before the product is captured (1..15)
DIV_LAT, 8, cycles FunctC=1111 is held before quotient/remainder are captured (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  decode presents a new operation this cycle
ALUOp  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type via Funct, 11 illegal
Funct  input  6  R-type function field
b_is_zero  input  1  ALU B operand == 0; sampled at div accept
alu_out  input  32  ALU result (product or quotient)
alu_rem  input  32  divider remainder
FunctC  output  4  ALU function code
stall  output  1  hold upstream pipeline
op_done  output  1  one-cycle pulse when a mult/div completes
hi  output  32  HI register
lo  output  32  LO register
mf_data  output  32  HI or LO value for mfhi/mflo
mf_valid  output  1  mf_data valid this cycle
illegal  output  1  unsupported ALUOp/Funct accepted this cycle
div_err  output  1  sticky; set by divide-by-zero

Behaviour:
- Reset (async, immediate): state=IDLE, FunctC=4'b0010, all other outputs 0, counter 0.
- Combinational decode while IDLE:
  - ALUOp 00 -> 0010; ALUOp 01 -> 0110.
  - ALUOp 10, by Funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 0011, 100110 -> 0100, 011000 -> 1010, 011010 -> 1111.
  - Funct 010000 (mfhi) / 010010 (mflo): FunctC=0010, mf_data=hi/lo, mf_valid=op_valid.
  - Any other Funct, or ALUOp 11: FunctC=0010, illegal=op_valid.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT, DONE.
  - IDLE + op_valid + mult: counter=MUL_LAT-1, go MUL_WAIT.
  - IDLE + op_valid + div with b_is_zero=0: counter=DIV_LAT-1, go DIV_WAIT.
  - IDLE + op_valid + div with b_is_zero=1: set div_err, HI/LO unchanged, stay IDLE, no stall.
  - MUL_WAIT / DIV_WAIT: FunctC registered and held at 1010 / 1111, stall=1. Counter decrements each cycle; at 0 go DONE.
  - DONE (1 cycle): stall=0, op_done=1. Mult: lo<=alu_out, hi<=0. Div: lo<=alu_out, hi<=alu_rem. Next state IDLE.
- Latency: accept cycle + LAT wait cycles + DONE cycle. stall is asserted from the cycle after accept through the last wait cycle.
- op_valid is ignored while stall=1 (upstream holds its instruction).
- op_valid in DONE is accepted as in IDLE (back-to-back).
- mfhi/mflo accepted in DONE returns the pre-capture HI/LO (see optional feature).
- Counter saturates: never wraps below 0.
- div_err clears only on reset.
- Reset mid-operation aborts without an HI/LO update.
- Zero-flag generation stays in the ALU; it is not this block's concern.

Optional Feature:
- Macro HILO_BYPASS_EN.
- Defined: mfhi/mflo in the DONE cycle returns the value being captured (alu_rem/0 or alu_out). Back-to-back mult->mflo then sees the new product.
- Undefined: mf_data always reflects the registered hi/lo. Software must insert one instruction between mult/div and mfhi/mflo.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - FunctC constants: FC_AND=0000, FC_OR=0001, FC_ADD=0010, FC_NOR=0011, FC_XOR=0100, FC_SUB=0110, FC_MUL=1010, FC_DIV=1111.
  - Funct field constants.
  - ALUOp constants.
  - FSM state enum.
- One natural sub-module: alu_funct_decode, purely combinational ALUOp/Funct -> FunctC/is_mul/is_div/is_mf/illegal. The FSM, counter and HI/LO stay in the top.

Test Plan:
- After reset, check FunctC=0010, stall=0, hi=lo=0. Then ALUOp=10 with each Funct 100000/100010/100100/100101/100111/100110 -> FunctC 0010/0110/0000/0001/0011/0100, no stall.
- mult (MUL_LAT=4), alu_out=0x0000_0F0F -> stall high 4 cycles, FunctC=1010 held; op_done pulses; lo=0x0000_0F0F, hi=0. Following mflo returns 0x0000_0F0F.
- div with alu_out=7, alu_rem=3 (DIV_LAT=8) -> 8 stall cycles; lo=7, hi=3. div with b_is_zero=1 -> div_err=1, no stall, HI/LO unchanged.
- ALUOp=11 or Funct=111111 -> illegal=1 for that cycle, FunctC=0010.
- Assert reset on the 3rd cycle of DIV_WAIT -> outputs return to reset values immediately; HI/LO keep the reset value 0.
- mult then mflo accepted in the DONE cycle -> with HILO_BYPASS_EN mf_data = the new product; without it, mf_data = the old lo.
